h_syncer: RTL and testbench

//  Horizontal timing generator for the VGA path (640x480@60 by default). Divides the board

---
 rtl/h_syncer.sv | 69 ++++++
 tb/tb_h_syncer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/h_syncer.sv
// Horizontal timing generator: divides clk down to a pixel tick, counts
// pixels per line and decodes sync, active window, column and line-end pulse.
module h_syncer #(
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   CLK_DIV   = 4,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic       pixel_tick,
  output logic       h_sync,
  output logic       h_active,
  output logic [9:0] pixel_x,
  output logic       line_complete
);

  localparam int H_TOTAL   = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
  localparam int VIS_START = H_SYNC + H_BACK;
  localparam int VIS_END   = VIS_START + H_VISIBLE;

  localparam logic [3:0] DIV_LAST  = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] VIS_LO    = 10'(VIS_START);
  localparam logic [9:0] VIS_HI    = 10'(VIS_END);

  logic [3:0] div_cnt_q, div_cnt_d;
  logic [9:0] h_count_q, h_count_d;
  logic       div_last;

  // CLK_DIV=1 leaves div_cnt stuck at 0, which equals DIV_LAST, so the tick follows en.
  assign div_last   = (div_cnt_q == DIV_LAST);
  assign pixel_tick = en & div_last;

  // Next-state for the clock divider and the pixel counter; both hold while en is low.
  always_comb begin
    div_cnt_d = div_cnt_q;
    h_count_d = h_count_q;
    if (en) begin
      div_cnt_d = div_last ? 4'd0 : div_cnt_q + 4'd1;
    end
    if (pixel_tick) begin
      h_count_d = (h_count_q == H_LAST) ? 10'd0 : h_count_q + 10'd1;
    end
  end

  // Counter registers; reset clears them immediately, truncating the current line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= 4'd0;
      h_count_q <= 10'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_count_q <= h_count_d;
    end
  end

  // Outputs decode straight from the registered count, so there is no extra latency.
  assign h_sync        = (h_count_q < SYNC_END) ? SYNC_POL : ~SYNC_POL;
  assign h_active      = (h_count_q >= VIS_LO) && (h_count_q < VIS_HI);
  assign pixel_x       = h_active ? (h_count_q - VIS_LO) : 10'd0;
  // Coincides with the tick that wraps h_count, so downstream advances on the same edge.
  assign line_complete = pixel_tick & (h_count_q == H_LAST);

endmodule

// File: tb/tb_h_syncer.sv
// Bench for h_syncer: two instances (CLK_DIV=4 and CLK_DIV=1) sharing clk/reset/en,
// checked against an arithmetic model driven by the count of enabled clock edges.
module tb_h_syncer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b1;

  logic       pt4, hs4, ha4, lc4;
  logic [9:0] px4;
  logic       pt1, hs1, ha1, lc1;
  logic [9:0] px1;

  always #5 clk = ~clk;

  h_syncer #(.CLK_DIV(4)) u_div4 (
    .clk(clk), .reset(reset), .en(en), .pixel_tick(pt4), .h_sync(hs4),
    .h_active(ha4), .pixel_x(px4), .line_complete(lc4)
  );

  h_syncer #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .reset(reset), .en(en), .pixel_tick(pt1), .h_sync(hs1),
    .h_active(ha1), .pixel_x(px1), .line_complete(lc1)
  );

  wire [13:0] a4 = {pt4, hs4, ha4, px4, lc4};
  wire [13:0] a1 = {pt1, hs1, ha1, px1, lc1};

  // Number of enabled clock edges since reset last fell; everything follows from it.
  longint e = 0;
  always @(posedge clk or posedge reset)
    if (reset) e <= 0;
    else if (en) e <= e + 1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected {pixel_tick, h_sync, h_active, pixel_x, line_complete} for 640x480 defaults.
  function automatic logic [13:0] model(input longint ev, input int div, input logic en_v);
    int h, ph;
    logic tk, sy, ac, lc;
    logic [9:0] px;
    h  = int'((ev / div) % 800);
    ph = int'(ev % div);
    tk = en_v && (ph == div - 1);
    sy = (h < 96) ? 1'b0 : 1'b1;
    ac = (h >= 144) && (h < 784);
    px = ac ? 10'(h - 144) : 10'd0;
    lc = tk && (h == 799);
    return {tk, sy, ac, px, lc};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      n_cmp += 2;
      if (a4 !== 14'h0000) begin
        n_bad++; $display("FAIL reset_div4 got=%h exp=%h", a4, 14'h0000);
      end
      if (a1 !== 14'h2000) begin
        n_bad++; $display("FAIL reset_div1 got=%h exp=%h", a1, 14'h2000);
      end
    end
    @(negedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_free_run();
    int last4 = -1, last1 = -1, run = 0, exp_run;
    bit seen_edge = 0;
    logic prev_hs;
    prev_hs = hs4;
    for (int i = 0; i < 6500; i++) begin
      @(negedge clk); #1;
      n_cmp += 2;
      if (a4 !== model(e, 4, en)) begin
        n_bad++; $display("FAIL free_run_div4 cyc=%0d got=%h exp=%h", cyc, a4, model(e, 4, en));
      end
      if (a1 !== model(e, 1, en)) begin
        n_bad++; $display("FAIL free_run_div1 cyc=%0d got=%h exp=%h", cyc, a1, model(e, 1, en));
      end
      if (lc4) begin
        if (last4 >= 0) begin
          n_cmp++;
          if (cyc - last4 !== 3200) begin
            n_bad++; $display("FAIL line_period_div4 got=%0d exp=3200", cyc - last4);
          end
        end
        last4 = cyc;
      end
      if (lc1) begin
        if (last1 >= 0) begin
          n_cmp++;
          if (cyc - last1 !== 800) begin
            n_bad++; $display("FAIL line_period_div1 got=%0d exp=800", cyc - last1);
          end
        end
        last1 = cyc;
      end
      if (hs4 === prev_hs) run++;
      else begin
        if (seen_edge) begin
          exp_run = prev_hs ? 2816 : 384;
          n_cmp++;
          if (run !== exp_run) begin
            n_bad++; $display("FAIL sync_run_len level=%0b got=%0d exp=%0d", prev_hs, run, exp_run);
          end
        end
        seen_edge = 1;
        run = 1;
        prev_hs = hs4;
      end
    end
    n_cmp++;
    if (last4 < 0) begin
      n_bad++; $display("FAIL free_run_no_line_complete got=none exp=pulse");
    end
  endtask

  task automatic test_enable_stall();
    int t0, k;
    k = 0;
    do begin
      @(negedge clk); #1; k++;
      n_cmp++;
      if (a4 !== model(e, 4, en)) begin
        n_bad++; $display("FAIL stall_pre got=%h exp=%h", a4, model(e, 4, en));
      end
    end while (lc4 !== 1'b1 && k < 4000);
    t0 = cyc;
    k = 0;
    do begin
      @(negedge clk); #1; k++;
      n_cmp++;
      if (a4 !== model(e, 4, en)) begin
        n_bad++; $display("FAIL stall_seek got=%h exp=%h", a4, model(e, 4, en));
      end
    end while (!((e % 4) == 0 && ((e / 4) % 800) == 500) && k < 4000);
    en = 1'b0;
    for (int i = 0; i < 37; i++) begin
      @(negedge clk); #1;
      n_cmp += 2;
      if ({pt4, px4, lc4} !== {1'b0, 10'd356, 1'b0}) begin
        n_bad++; $display("FAIL stall_hold got=%b/%0d exp=0/356", pt4, px4);
      end
      if (a1 !== model(e, 1, en)) begin
        n_bad++; $display("FAIL stall_div1 got=%h exp=%h", a1, model(e, 1, en));
      end
    end
    en = 1'b1;
    k = 0;
    do begin
      @(negedge clk); #1; k++;
      n_cmp++;
      if (a4 !== model(e, 4, en)) begin
        n_bad++; $display("FAIL stall_post got=%h exp=%h", a4, model(e, 4, en));
      end
    end while (lc4 !== 1'b1 && k < 5000);
    n_cmp++;
    if (cyc - t0 !== 3237) begin
      n_bad++; $display("FAIL stalled_line_len got=%0d exp=3237", cyc - t0);
    end
  endtask

  task automatic test_reset_midline();
    int k, k1;
    k = 0;
    do begin
      @(negedge clk); #1; k++;
    end while (!((e % 4) == 2 && ((e / 4) % 800) == 700) && k < 4000);
    n_cmp++;
    if (px4 !== 10'd556) begin
      n_bad++; $display("FAIL midline_pre_px got=%0d exp=556", px4);
    end
    reset = 1'b1;
    #1;
    n_cmp += 2;
    if (a4 !== 14'h0000) begin
      n_bad++; $display("FAIL midline_async_div4 got=%h exp=%h", a4, 14'h0000);
    end
    if (a1 !== 14'h2000) begin
      n_bad++; $display("FAIL midline_async_div1 got=%h exp=%h", a1, 14'h2000);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({a4, lc1} !== 15'h0000) begin
        n_bad++; $display("FAIL midline_hold got=%h/%b exp=0000/0", a4, lc1);
      end
    end
    reset = 1'b0;
    k = 0; k1 = -1;
    do begin
      @(negedge clk); #1; k++;
      if (lc1 === 1'b1 && k1 < 0) k1 = k;
      n_cmp += 2;
      if (a4 !== model(e, 4, en)) begin
        n_bad++; $display("FAIL midline_restart_div4 got=%h exp=%h", a4, model(e, 4, en));
      end
      if (a1 !== model(e, 1, en)) begin
        n_bad++; $display("FAIL midline_restart_div1 got=%h exp=%h", a1, model(e, 1, en));
      end
    end while (lc4 !== 1'b1 && k < 4000);
    n_cmp += 2;
    if (k + 1 !== 3200) begin
      n_bad++; $display("FAIL first_line_edges_div4 got=%0d exp=3200", k + 1);
    end
    if (k1 + 1 !== 800) begin
      n_bad++; $display("FAIL first_line_edges_div1 got=%0d exp=800", k1 + 1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 499) == 0);
      en    = ($urandom_range(0, 9) != 0);
      #1;
      n_cmp += 2;
      if (a4 !== model(e, 4, en)) begin
        n_bad++; $display("FAIL random_div4 cyc=%0d got=%h exp=%h", cyc, a4, model(e, 4, en));
      end
      if (a1 !== model(e, 1, en)) begin
        n_bad++; $display("FAIL random_div1 cyc=%0d got=%h exp=%h", cyc, a1, model(e, 1, en));
      end
    end
    reset = 1'b0;
    en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_enable_stall();
    test_reset_midline();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
